// File: rtl/task_gen_pkg.sv
// Shared definitions for the task generator.
// Holds the geometry constants, the derived per-tree depth and the stored task
// record used by the top, the interface and the arbiter.
package task_gen_pkg;

  localparam int PTW       = 16;    // priority width
  localparam int MTW       = 2;     // metadata width
  localparam int CTW       = 16;    // per-tree occupancy counter width
  localparam int LEVEL     = 4;     // downstream tree depth, interface compatibility only
  localparam int TREE_NUM  = 4;     // number of per-tree queues, power of 2
  localparam int FIFO_SIZE = 2048;  // total entries across all queues

  localparam int TREE_NUM_BITS = $clog2(TREE_NUM);
  localparam int D             = FIFO_SIZE / TREE_NUM;     // per-tree depth
  localparam int PTR_W         = (D > 1) ? $clog2(D) : 1;
  localparam int ADDR_W        = $clog2(FIFO_SIZE);
  localparam int DW            = MTW + PTW;                // task payload width

  typedef struct packed {
    logic [PTW-1:0] prio;
    logic [DW-1:0]  data;
  } task_t;

  // Per-tree pointers wrap at D, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(D - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/task_generator_if.sv
// Push/pop bus of the task generator.
//   master : drives push request, pop strobe; observes popped task and full flag
//   slave  : the task generator itself
interface task_generator_if import task_gen_pkg::*; ();

  logic [TREE_NUM_BITS-1:0] i_push_tree_id;
  logic [PTW-1:0]           i_push_priority;
  logic                     i_push;
  logic [DW-1:0]            i_push_data;
  logic                     i_pop;
  logic [TREE_NUM_BITS-1:0] o_pop_tree_id;
  logic [DW-1:0]            o_pop_data;
  logic                     o_task_fifo_full;

  modport master (
    output i_push_tree_id, i_push_priority, i_push, i_push_data, i_pop,
    input  o_pop_tree_id, o_pop_data, o_task_fifo_full
  );

  modport slave (
    input  i_push_tree_id, i_push_priority, i_push, i_push_data, i_pop,
    output o_pop_tree_id, o_pop_data, o_task_fifo_full
  );

endinterface

// File: rtl/task_gen_arbiter.sv
// Combinational head selector.
// Picks, among non-empty trees, the one whose head priority is numerically
// lowest; equal priorities resolve to the lowest tree id.
//   head_prio : head priority of each tree (ignored where nonempty is 0)
//   nonempty  : per-tree occupancy mask
//   win_id    : selected tree (0 when any_valid is 0)
//   any_valid : at least one tree is non-empty
module task_gen_arbiter import task_gen_pkg::*; (
  input  logic [PTW-1:0]           head_prio [TREE_NUM],
  input  logic [TREE_NUM-1:0]      nonempty,
  output logic [TREE_NUM_BITS-1:0] win_id,
  output logic                     any_valid
);

  logic [PTW-1:0] best_prio;

  // Ascending scan with strict less-than keeps the lowest id on ties.
  always_comb begin
    win_id    = '0;
    any_valid = 1'b0;
    best_prio = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      if (nonempty[t] && (!any_valid || head_prio[t] < best_prio)) begin
        win_id    = TREE_NUM_BITS'(t);
        best_prio = head_prio[t];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/task_generator.sv
// Priority-ordered task buffer in front of the vPIFO tree array.
// TREE_NUM FIFO queues share one storage array (tree t owns addresses
// t*D .. t*D+D-1). A pop serves the head with the lowest priority across
// trees; within a tree order is strictly FIFO.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : push request, pop strobe, registered popped task, full flag
module task_generator import task_gen_pkg::*; (
  input logic             i_clk,
  input logic             i_rst,
  task_generator_if.slave bus
);

  task_t                    mem [FIFO_SIZE];
  logic [PTR_W-1:0]         head_q [TREE_NUM];
  logic [PTR_W-1:0]         tail_q [TREE_NUM];
  logic [CTW-1:0]           cnt_q  [TREE_NUM];
  logic [CTW-1:0]           cnt_nxt[TREE_NUM];
  logic [PTW-1:0]           head_prio[TREE_NUM];
  logic [TREE_NUM-1:0]      nonempty;
  logic [TREE_NUM_BITS-1:0] win_id;
  logic                     any_valid;
  logic                     push_ok;
  logic                     pop_ok;
  logic                     full_nxt;
  task_t                    win_task;

  logic [DW-1:0]            pop_data_p1;
  logic [TREE_NUM_BITS-1:0] pop_tree_p1;
  logic                     full_p1;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [TREE_NUM_BITS-1:0] t,
                                                  input logic [PTR_W-1:0]         p);
    return ADDR_W'(t) * ADDR_W'(D) + ADDR_W'(p);
  endfunction

  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      nonempty[t]  = (cnt_q[t] != '0);
      head_prio[t] = mem[slot_addr(TREE_NUM_BITS'(t), head_q[t])].prio;
    end
  end

  task_gen_arbiter u_arb (
    .head_prio (head_prio),
    .nonempty  (nonempty),
    .win_id    (win_id),
    .any_valid (any_valid)
  );

  // Acceptance uses pre-edge counts only, so a same-edge pop never frees
  // room for a push, and a fresh entry is not visible to the arbiter yet.
  always_comb begin
    win_task = mem[slot_addr(win_id, head_q[win_id])];
    push_ok  = bus.i_push && (cnt_q[bus.i_push_tree_id] < CTW'(D));
    pop_ok   = bus.i_pop && any_valid;
    full_nxt = 1'b0;
    for (int t = 0; t < TREE_NUM; t++) begin
      cnt_nxt[t] = cnt_q[t];
      if (push_ok && bus.i_push_tree_id == TREE_NUM_BITS'(t)) cnt_nxt[t] = cnt_nxt[t] + 1'b1;
      if (pop_ok && win_id == TREE_NUM_BITS'(t))              cnt_nxt[t] = cnt_nxt[t] - 1'b1;
      if (cnt_nxt[t] == CTW'(D))                              full_nxt   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[slot_addr(bus.i_push_tree_id, tail_q[bus.i_push_tree_id])] <=
        '{prio: bus.i_push_priority, data: bus.i_push_data};
    end
  end

  // ---- stage p1: queue state update and registered pop result ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        head_q[t] <= '0;
        tail_q[t] <= '0;
        cnt_q[t]  <= '0;
      end
      pop_data_p1 <= '0;
      pop_tree_p1 <= '0;
      full_p1     <= 1'b0;
    end else begin
      for (int t = 0; t < TREE_NUM; t++) cnt_q[t] <= cnt_nxt[t];
      if (push_ok) tail_q[bus.i_push_tree_id] <= ptr_inc(tail_q[bus.i_push_tree_id]);
      if (pop_ok) begin
        head_q[win_id] <= ptr_inc(head_q[win_id]);
        pop_data_p1    <= win_task.data;
        pop_tree_p1    <= win_id;
      end
      full_p1 <= full_nxt;
    end
  end

  assign bus.o_pop_data       = pop_data_p1;
  assign bus.o_pop_tree_id    = pop_tree_p1;
  assign bus.o_task_fifo_full = full_p1;

endmodule

// File: tb/tb_task_generator.sv
module tb_task_generator;
  import task_gen_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  task_generator_if bus();

  task_generator dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int tree;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   mq_prio[TREE_NUM][$];
  int   mq_data[TREE_NUM][$];
  int   last_tree;
  int   last_data;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.i_push          = 1'b0;
    bus.i_pop           = 1'b0;
    bus.i_push_tree_id  = '0;
    bus.i_push_priority = '0;
    bus.i_push_data     = '0;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    for (int t = 0; t < TREE_NUM; t++) begin
      mq_prio[t].delete();
      mq_data[t].delete();
    end
    exp_q.delete();
    last_tree = 0;
    last_data = 0;
  endtask

  // One clock: drive push/pop, update reference model, then check after edge.
  task automatic cycle(input bit push, input int tree, input int prio, input int data,
                       input bit pop, input string tag);
    int   w;
    int   bp;
    int   pre_size;
    bit   full;
    exp_t e;
    bus.i_push          = push;
    bus.i_push_tree_id  = TREE_NUM_BITS'(tree);
    bus.i_push_priority = PTW'(prio);
    bus.i_push_data     = DW'(data);
    bus.i_pop           = pop;
    pre_size = mq_prio[tree].size();
    if (pop) begin
      w  = -1;
      bp = 0;
      for (int t = 0; t < TREE_NUM; t++) begin
        if (mq_prio[t].size() > 0) begin
          if (w < 0 || mq_prio[t][0] < bp) begin
            w  = t;
            bp = mq_prio[t][0];
          end
        end
      end
      if (w >= 0) begin
        last_tree = w;
        last_data = mq_data[w].pop_front();
        void'(mq_prio[w].pop_front());
      end
      e.tree = last_tree;
      e.data = last_data;
      exp_q.push_back(e);
    end
    if (push && pre_size < D) begin
      mq_prio[tree].push_back(prio);
      mq_data[tree].push_back(data);
    end
    @(posedge i_clk);
    #1;
    bus.i_push = 1'b0;
    bus.i_pop  = 1'b0;
    if (pop) begin
      e = exp_q.pop_front();
      check_eq({tag, "_tree"}, bus.o_pop_tree_id, e.tree);
      check_eq({tag, "_data"}, bus.o_pop_data, e.data);
    end
    full = 1'b0;
    for (int t = 0; t < TREE_NUM; t++) if (mq_prio[t].size() == D) full = 1'b1;
    check_eq({tag, "_full"}, bus.o_task_fifo_full, full);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pri_exp[12] = '{4097, 4098, 4099, 4100, 8193, 8194, 8195, 8196,
                        12289, 12290, 12291, 12292};

    // Reset state and pop on empty
    do_reset();
    check_eq("rst_data", bus.o_pop_data, 0);
    check_eq("rst_tree", bus.o_pop_tree_id, 0);
    check_eq("rst_full", bus.o_task_fifo_full, 0);
    cycle(0, 0, 0, 0, 1, "empty_pop");
    check_eq("empty_pop_const", bus.o_pop_data, 0);

    // Priority ordering across trees
    for (int j = 1; j <= 4; j++)
      for (int i = 1; i <= 3; i++)
        cycle(1, i, i, 4096 * i + j, 0, "prio_push");
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 0, 1, "prio_pop");
      check_eq("prio_const_data", bus.o_pop_data, pri_exp[k]);
      check_eq("prio_const_tree", bus.o_pop_tree_id, k / 4 + 1);
    end
    cycle(0, 0, 0, 0, 1, "prio_hold");
    check_eq("prio_hold_data", bus.o_pop_data, 12292);
    check_eq("prio_hold_tree", bus.o_pop_tree_id, 3);

    // Tie-break and head-only competition
    cycle(1, 2, 5, 20, 0, "tie_push");
    cycle(1, 1, 5, 10, 0, "tie_push");
    cycle(1, 1, 1, 11, 0, "tie_push");
    cycle(0, 0, 0, 0, 1, "tie_pop");
    check_eq("tie_c0_data", bus.o_pop_data, 10);
    check_eq("tie_c0_tree", bus.o_pop_tree_id, 1);
    cycle(0, 0, 0, 0, 1, "tie_pop");
    check_eq("tie_c1_data", bus.o_pop_data, 11);
    check_eq("tie_c1_tree", bus.o_pop_tree_id, 1);
    cycle(0, 0, 0, 0, 1, "tie_pop");
    check_eq("tie_c2_data", bus.o_pop_data, 20);
    check_eq("tie_c2_tree", bus.o_pop_tree_id, 2);

    // Full queue
    for (int k = 0; k < D; k++) begin
      cycle(1, 0, 300, k + 1000, 0, "fill");
      if (k == D - 2) check_eq("full_not_yet", bus.o_task_fifo_full, 0);
    end
    check_eq("full_set", bus.o_task_fifo_full, 1);
    cycle(1, 0, 300, 9999, 0, "drop");
    for (int k = 0; k < D; k++) begin
      cycle(0, 0, 0, 0, 1, "drain");
      check_eq("drain_const", bus.o_pop_data, k + 1000);
      if (k == 0) check_eq("full_clear", bus.o_task_fifo_full, 0);
    end

    // Simultaneous push and pop on empty queues
    cycle(1, 0, 9, 7, 1, "simul");
    check_eq("simul_hold_data", bus.o_pop_data, D - 1 + 1000);
    cycle(0, 0, 0, 0, 1, "simul_next");
    check_eq("simul_next_data", bus.o_pop_data, 7);
    check_eq("simul_next_tree", bus.o_pop_tree_id, 0);

    // Pointer wrap-around on tree 3, occupancy stays <= 3
    for (int k = 0; k < 1500; k++) cycle(1, 3, k % 7, k + 1, (k >= 2), "wrap");
    cycle(0, 0, 0, 0, 1, "wrap_tail");
    cycle(0, 0, 0, 0, 1, "wrap_tail");
    check_eq("wrap_last", bus.o_pop_data, 1500);

    // Reset mid-operation discards queued tasks
    cycle(1, 1, 2, 33, 0, "mid_push");
    cycle(1, 1, 2, 34, 0, "mid_push");
    do_reset();
    check_eq("mid_rst_data", bus.o_pop_data, 0);
    check_eq("mid_rst_full", bus.o_task_fifo_full, 0);
    cycle(0, 0, 0, 0, 1, "mid_empty_pop");
    cycle(1, 2, 4, 55, 0, "mid_new_push");
    cycle(0, 0, 0, 0, 1, "mid_new_pop");
    check_eq("mid_new_data", bus.o_pop_data, 55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/task_generator.md
Name: task_generator

Overview:
- Priority-ordered task buffer in front of the vPIFO tree array.
- Accepts push tasks (tree id, priority, data) into TREE_NUM per-tree FIFO queues held in one storage array.
- A pop returns the head task of the non-empty tree whose head has the numerically lowest priority. Ties go to the lowest tree id.
- Output is one registered result per pop.

Parameters:
- PTW, 16, priority width in bits.
- MTW, 2 (=TREE_NUM_BITS), metadata width; push/pop data width is MTW+PTW.
- CTW, 16, per-tree occupancy counter width; must be >= log2(FIFO_SIZE/TREE_NUM)+1.
- LEVEL, 4, depth of the downstream tree; carried for interface compatibility, no functional effect.
- TREE_NUM, 4, number of logical trees/queues; power of 2, >= 2.
- FIFO_SIZE, 2048, total entries; multiple of TREE_NUM. Per-tree depth D = FIFO_SIZE/TREE_NUM.
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_push_tree_id  in  TREE_NUM_BITS  target queue of push.
- i_push_priority  in  PTW  priority of pushed task; lower value = served first.
- i_push  in  1  push strobe, one task per cycle.
- i_push_data  in  MTW+PTW  task payload.
- i_pop  in  1  pop strobe, one task per cycle.
- o_pop_tree_id  out  TREE_NUM_BITS  tree id of last popped task.
- o_pop_data  out  MTW+PTW  payload of last popped task.
- o_task_fifo_full  out  1  high while any per-tree queue holds D entries.

Behaviour:
- Reset (sampled on i_clk while i_rst=1):
  - all head/tail pointers and counters = 0;
  - o_pop_data = 0, o_pop_tree_id = 0, o_task_fifo_full = 0;
  - storage contents don't-care.
  - Reset mid-operation discards all queued tasks.
- Storage: entry {priority, data} at address tree_id*D + ptr. Pointers wrap modulo D.
- Push (i_push=1 at edge):
  - if count[tree] < D (pre-edge state): write entry at tail, tail++, count++;
  - otherwise drop silently, no state change.
- Pop (i_pop=1 at edge):
  - Eligible trees are those with count > 0 in pre-edge state.
  - Winner = eligible tree with minimum head priority; tie -> lowest tree id.
  - At that edge: o_pop_data <= head data, o_pop_tree_id <= winner, head++, count--.
  - Outputs are visible the cycle after the pop strobe.
  - If no tree is eligible: outputs hold previous values, no state change.
- Simultaneous push+pop:
  - Both act in the same cycle.
  - A task pushed at edge N is not eligible for a pop at edge N; it is eligible from edge N+1.
  - Push to a full queue is dropped even if the same edge pops that queue.
- Within one tree, order is strict FIFO regardless of the priority of later entries. Only head priorities compete across trees.
- o_task_fifo_full is registered from post-edge counts: high iff any count == D.
- Outputs hold between pops. There is no valid signal.

Decomposition:
- Package task_gen_pkg holds:
  - TREE_NUM_BITS and the derived depth D;
  - typedef task_t {priority[PTW], data[MTW+PTW]}.
- One sub-module, task_gen_arbiter: combinational min-priority / lowest-id selector over TREE_NUM head priorities plus a non-empty mask. Outputs winner id and any_valid.

Test Plan:
- Reset: hold i_rst 3 cycles, then release. Required: o_pop_data=0, o_pop_tree_id=0, o_task_fifo_full=0; a pop on empty leaves outputs at 0.
- Priority ordering:
  - Push, j=1..4 outer, trees i=1..3 inner: tree i, priority i, data 4096*i+j (12 pushes, back to back).
  - Then 12 consecutive pops.
  - Required o_pop_data in order: 4097,4098,4099,4100, 8193..8196, 12289..12292.
  - Matching o_pop_tree_id: 1 x4, 2 x4, 3 x4.
  - A 13th pop holds 12292 / tree 3.
- Tie-break and head-only competition:
  - Push tree2 prio 5 data 20, then tree1 prio 5 data 10, then tree1 prio 1 data 11.
  - Pops give 10 (tree1), 11 (tree1), 20 (tree2).
- Full:
  - Push D=512 tasks to tree 0: o_task_fifo_full rises the cycle after the 512th push.
  - A 513th push is dropped.
  - One pop clears full; the 512 pops return data in push order.
- Simultaneous push+pop:
  - Queues empty; push tree0 data 7 and pop at the same edge. Pop returns nothing, outputs unchanged.
  - Next pop returns 7 / tree 0.
- Wrap-around: push/pop tree3 1500 times, interleaved with occupancy <= 3. Every pop equals the matching push; no full.
